// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate strobe, row/column counters and the sync,
// blanking and line/frame markers, all registered and aligned to the counters.
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pix_en,
  output logic [9:0] pix_row,
  output logic [9:0] pix_col,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0]  DIV_LAST    = 4'(CLK_DIV - 1);
  localparam logic [9:0]  COL_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  ROW_LAST    = 10'(V_TOTAL - 1);
  // Region bounds are one bit wider so a total of exactly 1024 cannot wrap.
  localparam logic [10:0] COL_VIS_END = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START    = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END      = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] ROW_VIS_END = 11'(V_ACTIVE);
  localparam logic [10:0] VS_START    = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END      = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        SYNC_ON     = 1'(SYNC_POL);

  logic [3:0] div_cnt;
  logic [9:0] col_nxt;
  logic [9:0] row_nxt;
  logic       vo_nxt;
  logic       hs_nxt;
  logic       vs_nxt;
  logic       ls_nxt;
  logic       fs_nxt;

  always_comb begin
    col_nxt = pix_col;
    row_nxt = pix_row;
    if (pix_en) begin
      if (pix_col == COL_LAST) begin
        col_nxt = '0;
        row_nxt = (pix_row == ROW_LAST) ? 10'd0 : pix_row + 10'd1;
      end else begin
        col_nxt = pix_col + 10'd1;
      end
    end
  end

  // Decoded from the next counter values so the registered flags line up
  // with the counters they describe.
  always_comb begin
    vo_nxt = ({1'b0, col_nxt} < COL_VIS_END) && ({1'b0, row_nxt} < ROW_VIS_END);
    hs_nxt = (({1'b0, col_nxt} >= HS_START) && ({1'b0, col_nxt} < HS_END)) ? SYNC_ON : ~SYNC_ON;
    vs_nxt = (({1'b0, row_nxt} >= VS_START) && ({1'b0, row_nxt} < VS_END)) ? SYNC_ON : ~SYNC_ON;
    ls_nxt = pix_en && (col_nxt == 10'd0);
    fs_nxt = ls_nxt && (row_nxt == 10'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt     <= '0;
      pix_en      <= 1'b0;
      pix_col     <= COL_LAST;
      pix_row     <= ROW_LAST;
      video_on    <= 1'b0;
      hsync       <= ~SYNC_ON;
      vsync       <= ~SYNC_ON;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        pix_en  <= 1'b1;
      end else begin
        div_cnt <= div_cnt + 4'd1;
        pix_en  <= 1'b0;
      end
      pix_col     <= col_nxt;
      pix_row     <= row_nxt;
      video_on    <= vo_nxt;
      hsync       <= hs_nxt;
      vsync       <= vs_nxt;
      line_start  <= ls_nxt;
      frame_start <= fs_nxt;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized reset/run bench for vga_timing_gen; three builds (full-size default,
// small geometry, small geometry with CLK_DIV=1 and inverted sync) against a pixel-count model.
module tb_vga_timing_gen;

  typedef struct {
    int d;
    int ha, hf, hs, hb;
    int va, vf, vs, vb;
    bit pol;
  } cfg_t;

  localparam cfg_t CFG_A = '{d: 4, ha: 16, hf: 2, hs: 3, hb: 2, va: 6, vf: 1, vs: 2, vb: 1, pol: 1'b0};
  localparam cfg_t CFG_B = '{d: 1, ha: 16, hf: 2, hs: 3, hb: 2, va: 6, vf: 1, vs: 2, vb: 1, pol: 1'b1};
  localparam cfg_t CFG_C = '{d: 4, ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33, pol: 1'b0};

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic       pe_a, vo_a, hs_a, vs_a, ls_a, fs_a;
  logic [9:0] row_a, col_a;
  logic       pe_b, vo_b, hs_b, vs_b, ls_b, fs_b;
  logic [9:0] row_b, col_b;
  logic       pe_c, vo_c, hs_c, vs_c, ls_c, fs_c;
  logic [9:0] row_c, col_c;

  logic [25:0] exp_a[$];
  logic [25:0] exp_b[$];
  logic [25:0] exp_c[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int run_len  = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV(4), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(0)
  ) dut_a (
    .clk(clk), .reset(reset), .pix_en(pe_a), .pix_row(row_a), .pix_col(col_a),
    .video_on(vo_a), .hsync(hs_a), .vsync(vs_a), .line_start(ls_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1)
  ) dut_b (
    .clk(clk), .reset(reset), .pix_en(pe_b), .pix_row(row_b), .pix_col(col_b),
    .video_on(vo_b), .hsync(hs_b), .vsync(vs_b), .line_start(ls_b), .frame_start(fs_b)
  );

  vga_timing_gen dut_c (
    .clk(clk), .reset(reset), .pix_en(pe_c), .pix_row(row_c), .pix_col(col_c),
    .video_on(vo_c), .hsync(hs_c), .vsync(vs_c), .line_start(ls_c), .frame_start(fs_c)
  );

  // n = clock edges with reset low since the last reset edge. The raster has
  // taken floor((n-1)/d) pixel steps; step k lands on linear pixel k-1 of the frame.
  function automatic logic [25:0] model(input cfg_t c, input bit rst, input int n);
    int ht, vt, k, kprev, pos, row, col;
    bit pe, adv, vo, hs, vs, ls, fs;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    if (rst)
      return {1'b0, 10'(vt - 1), 10'(ht - 1), 1'b0, ~c.pol, ~c.pol, 1'b0, 1'b0};
    pe    = (n % c.d) == 0;
    k     = (n - 1) / c.d;
    kprev = (n >= 2) ? (n - 2) / c.d : 0;
    adv   = (k != kprev);
    if (k == 0) begin
      row = vt - 1;
      col = ht - 1;
    end else begin
      pos = (k - 1) % (ht * vt);
      row = pos / ht;
      col = pos % ht;
    end
    vo = (col < c.ha) && (row < c.va);
    hs = ((col >= c.ha + c.hf) && (col < c.ha + c.hf + c.hs)) ? c.pol : ~c.pol;
    vs = ((row >= c.va + c.vf) && (row < c.va + c.vf + c.vs)) ? c.pol : ~c.pol;
    ls = adv && (col == 0);
    fs = ls && (row == 0);
    return {pe, 10'(row), 10'(col), vo, hs, vs, ls, fs};
  endfunction

  task automatic checkOutput(input string name, input logic [25:0] act, input logic [25:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s cycle %0d: got en=%b row=%0d col=%0d von/hs/vs/ls/fs=%b, expected en=%b row=%0d col=%0d von/hs/vs/ls/fs=%b",
               name, cyc, act[25], act[24:15], act[14:5], act[4:0], exp[25], exp[24:15], exp[14:5], exp[4:0]);
    end
  endtask

  // Drives reset for the given number of edges, queueing what each edge should produce.
  int n_since = 0;
  task automatic applyStimulus(input bit rst, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      reset = rst;
      if (rst) n_since = 0;
      else n_since++;
      exp_a.push_back(model(CFG_A, rst, n_since));
      exp_b.push_back(model(CFG_B, rst, n_since));
      exp_c.push_back(model(CFG_C, rst, n_since));
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every clock the DUTs present a new raster state, checked mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (exp_a.size() > 0) checkOutput("dut_a", {pe_a, row_a, col_a, vo_a, hs_a, vs_a, ls_a, fs_a}, exp_a.pop_front());
    if (exp_b.size() > 0) checkOutput("dut_b", {pe_b, row_b, col_b, vo_b, hs_b, vs_b, ls_b, fs_b}, exp_b.pop_front());
    if (exp_c.size() > 0) checkOutput("dut_c", {pe_c, row_c, col_c, vo_c, hs_c, vs_c, ls_c, fs_c}, exp_c.pop_front());
  end

  initial begin
    applyStimulus(1'b1, 3);
    // Long first run takes the full-size build through hsync and a line wrap.
    applyStimulus(1'b0, 3400);
    // Reset lands on an edge where dut_a holds pix_en (run length multiple of 4).
    for (int seg = 0; seg < 6; seg++) begin
      applyStimulus(1'b1, $urandom_range(1, 3));
      if (seg % 2 == 0) run_len = 4 * $urandom_range(60, 400);
      else run_len = $urandom_range(200, 1600);
      applyStimulus(1'b0, run_len);
    end
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 1000);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_a.size() + exp_b.size() + exp_c.size() == 0) n_pass++;
    else $display("[TB] FAIL drain: %0d expectations left unchecked, required 0",
                  exp_a.size() + exp_b.size() + exp_c.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
